// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache controller.
// Build option DCACHE_CTRL_PERF_EN (used in dcache_controller) enables the hit/miss counters.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int INDEX_W    = 4;
    localparam int TAG_W      = 23;
    localparam int LINE_W     = 256;
    localparam int SRAM_TAG_W = 25;
    localparam int WSEL_W     = 3;
    localparam int OFFSET_W   = 5;

    localparam int WSEL_LSB  = 2;
    localparam int WSEL_MSB  = 4;
    localparam int INDEX_LSB = 5;
    localparam int INDEX_MSB = 8;
    localparam int TAG_LSB   = 9;
    localparam int TAG_MSB   = 31;

    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_e;

    function automatic logic [SRAM_TAG_W-1:0] make_sram_tag(
        input logic             valid,
        input logic             dirty,
        input logic [TAG_W-1:0] tag
    );
        return {valid, dirty, tag};
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a 256-bit cache line and builds the line with that word replaced.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [LINE_W-1:0] merged
);

    logic [7:0] bit_base;

    assign bit_base = {word_sel, 5'b0};

    always_comb begin
        rdata  = line[bit_base +: WORD_W];
        merged = line;
        merged[bit_base +: WORD_W] = wdata;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: zero-latency hits, write-back/allocate/fill on miss.
// Define DCACHE_CTRL_PERF_EN to build saturating hit/miss counters; otherwise the perf ports read 0.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,

    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    output logic [INDEX_W-1:0]    sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,

    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,

    output logic [31:0]           perf_hit_cnt_o,
    output logic [31:0]           perf_miss_cnt_o
);

    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_index;
    logic [WSEL_W-1:0]  cpu_wsel;
    logic               unused_byte_offset;

    assign cpu_tag            = cpu_addr_i[TAG_MSB:TAG_LSB];
    assign cpu_index          = cpu_addr_i[INDEX_MSB:INDEX_LSB];
    assign cpu_wsel           = cpu_addr_i[WSEL_MSB:WSEL_LSB];
    assign unused_byte_offset = ^cpu_addr_i[WSEL_LSB-1:0];

    state_e             state_q;
    logic [TAG_W-1:0]   victim_tag_q;
    logic [LINE_W-1:0]  victim_data_q;
    logic [TAG_W-1:0]   miss_tag_q;
    logic [INDEX_W-1:0] miss_index_q;
    logic [LINE_W-1:0]  fill_data_q;

    logic              idle_req;
    logic              idle_hit;
    logic              idle_miss;
    logic [WORD_W-1:0] hit_word;
    logic [LINE_W-1:0] merged_line;

    assign idle_req  = (state_q == IDLE) && cpu_req_i;
    assign idle_hit  = idle_req && sram_hit_i;
    assign idle_miss = idle_req && !sram_hit_i;

    dcache_word_merge u_word_merge (
        .line     (sram_data_i),
        .word_sel (cpu_wsel),
        .wdata    (cpu_data_i),
        .rdata    (hit_word),
        .merged   (merged_line)
    );

    // Miss address is latched so the sequence finishes correctly even if cpu_req_i drops.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            miss_tag_q    <= '0;
            miss_index_q  <= '0;
            fill_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_miss) begin
                        victim_tag_q  <= sram_tag_i[TAG_W-1:0];
                        victim_data_q <= sram_data_i;
                        miss_tag_q    <= cpu_tag;
                        miss_index_q  <= cpu_index;
                        state_q       <= (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT])
                                         ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) state_q <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        fill_data_q <= mem_data_i;
                        state_q     <= FILL;
                    end
                end
                FILL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state register; IDLE must answer hits in the same cycle.
    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    sram_enable_o = cpu_req_i;
                    sram_write_o  = idle_hit && cpu_write_i;
                    sram_addr_o   = cpu_index;
                    sram_tag_o    = make_sram_tag(1'b1, idle_hit && cpu_write_i, cpu_tag);
                    sram_data_o   = merged_line;
                    cpu_data_o    = idle_hit ? hit_word : '0;
                    cpu_stall_o   = idle_miss;
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = line_addr(victim_tag_q, miss_index_q);
                    mem_data_o   = victim_data_q;
                end
                ALLOCATE: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = line_addr(miss_tag_q, miss_index_q);
                end
                FILL: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_addr_o   = miss_index_q;
                    sram_tag_o    = make_sram_tag(1'b1, 1'b0, miss_tag_q);
                    sram_data_o   = fill_data_q;
                end
                default: cpu_stall_o = 1'b0;
            endcase
        end
    end

`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (idle_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
`else
    assign perf_hit_cnt_o  = '0;
    assign perf_miss_cnt_o = '0;
`endif

endmodule
